udb_counter: RTL

- Parametrised successor to the team's 4-bit up/down counter with load.
- Generalises the count width and adds a programmable terminal value (limit) and a programmable step size.
- Selectable overflow mode: wrap, saturate, or one-shot.
- Provides registered terminal-count and done flags for use by downstream sequencers and shifters in the same datapath.

---
 rtl/udb_counter_pkg.sv | 15 +
 rtl/udb_counter_next.sv | 96 +++++++++
 rtl/udb_counter.sv | 95 +++++++++
 3 files changed

// File: rtl/udb_counter_pkg.sv
// Shared encodings for the udb_counter up/down counter family.
// Optional bounce mode is enabled with the UDB_COUNTER_BOUNCE_EN macro.
package udb_counter_pkg;

  typedef enum logic [1:0] {
    UDB_MODE_WRAP    = 2'b00,
    UDB_MODE_SAT     = 2'b01,
    UDB_MODE_BOUNCE  = 2'b10,
    UDB_MODE_ONESHOT = 2'b11
  } udb_mode_e;

  localparam logic UDB_DIR_UP = 1'b1;
  localparam logic UDB_DIR_DN = 1'b0;

endpackage

// File: rtl/udb_counter_next.sv
// Combinational next-count and boundary-cross computation for udb_counter.
// Bounce handling is compiled in only when UDB_COUNTER_BOUNCE_EN is defined.
module udb_counter_next
  import udb_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  i_out,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_direction,
  input  logic [1:0]        i_mode,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_cross
);

  // Two guard bits above the wider operand keep sums and differences exact.
  localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;

  logic [EW-1:0] w_zero;
  logic [EW-1:0] w_out;
  logic [EW-1:0] w_step;
  logic [EW-1:0] w_limit;
  logic [EW-1:0] w_mod;
  logic [EW-1:0] w_up_sum;
  logic [EW-1:0] w_dn_diff;
  logic [EW-1:0] w_deficit;
  logic [EW-1:0] w_up_wrap;
  logic [EW-1:0] w_dn_rem;
  logic [EW-1:0] w_dn_wrap;
  logic [EW-1:0] w_res;
  logic          w_up_cross;
  logic          w_dn_cross;

  assign w_zero    = {EW{1'b0}};
  assign w_limit   = EW'(i_limit);
  assign w_step    = EW'(i_step);
  // A count left above a freshly lowered limit is treated as sitting on the limit.
  assign w_out     = (i_out > i_limit) ? w_limit : EW'(i_out);
  assign w_mod     = w_limit + {{(EW-1){1'b0}}, 1'b1};
  assign w_up_sum  = w_out + w_step;
  assign w_dn_diff = w_out - w_step;
  assign w_deficit = w_step - w_out;
  assign w_up_cross = (w_up_sum > w_limit);
  assign w_dn_cross = (w_step > w_out);
  assign w_up_wrap = w_up_sum % w_mod;
  assign w_dn_rem  = w_deficit % w_mod;
  assign w_dn_wrap = (w_dn_rem == w_zero) ? w_zero : (w_mod - w_dn_rem);

  // Select the next count and cross flag for the active mode and direction.
  always_comb begin
    w_res   = w_out;
    o_cross = 1'b0;
    if (w_step == w_zero) begin
      w_res   = w_out;
      o_cross = 1'b0;
    end else begin
      case (udb_mode_e'(i_mode))
        UDB_MODE_SAT, UDB_MODE_ONESHOT: begin
          if (i_direction == UDB_DIR_UP) begin
            w_res   = w_up_cross ? w_limit : w_up_sum;
            o_cross = w_up_cross;
          end else begin
            w_res   = w_dn_cross ? w_zero : w_dn_diff;
            o_cross = w_dn_cross;
          end
        end
`ifdef UDB_COUNTER_BOUNCE_EN
        // Bounce turns around as soon as a boundary is reached, not only when passed.
        UDB_MODE_BOUNCE: begin
          if (i_direction == UDB_DIR_UP) begin
            w_res   = (w_up_sum >= w_limit) ? w_limit : w_up_sum;
            o_cross = (w_up_sum >= w_limit);
          end else begin
            w_res   = (w_step >= w_out) ? w_zero : w_dn_diff;
            o_cross = (w_step >= w_out);
          end
        end
`endif
        default: begin
          if (i_direction == UDB_DIR_UP) begin
            w_res   = w_up_wrap;
            o_cross = w_up_cross;
          end else begin
            w_res   = w_dn_cross ? w_dn_wrap : w_dn_diff;
            o_cross = w_dn_cross;
          end
        end
      endcase
    end
  end

  assign o_next = WIDTH'(w_res);

endmodule

// File: rtl/udb_counter.sv
// Parametrised up/down counter with load, limit, step, and wrap/saturate/one-shot modes.
// Define UDB_COUNTER_BOUNCE_EN to make mode 2'b10 a bounce counter instead of wrap.
module udb_counter
  import udb_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              udb_counter_clk,
  input  logic              udb_counter_rst,
  input  logic              udb_counter_en,
  input  logic              udb_counter_direction,
  input  logic              udb_counter_load,
  input  logic [WIDTH-1:0]  udb_counter_load_input,
  input  logic [WIDTH-1:0]  udb_counter_limit,
  input  logic [STEP_W-1:0] udb_counter_step,
  input  logic [1:0]        udb_counter_mode,
  output logic [WIDTH-1:0]  udb_counter_out,
  output logic              udb_counter_tc,
  output logic              udb_counter_done
);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_done;
  logic [WIDTH-1:0] w_next;
  logic             w_cross;
  logic             w_dir;
  logic             w_step_nz;
  logic             w_term;
  logic [WIDTH-1:0] w_load_val;

`ifdef UDB_COUNTER_BOUNCE_EN
  logic r_dir;
  assign w_dir = (udb_counter_mode == UDB_MODE_BOUNCE) ? r_dir : udb_counter_direction;
`else
  assign w_dir = udb_counter_direction;
`endif

  assign w_step_nz  = |udb_counter_step;
  assign w_load_val = (udb_counter_load_input > udb_counter_limit) ?
                      udb_counter_limit : udb_counter_load_input;
  assign w_term     = (udb_counter_direction == UDB_DIR_UP) ?
                      (w_next == udb_counter_limit) : (w_next == {WIDTH{1'b0}});

  udb_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .i_out       (r_out),
    .i_step      (udb_counter_step),
    .i_limit     (udb_counter_limit),
    .i_direction (w_dir),
    .i_mode      (udb_counter_mode),
    .o_next      (w_next),
    .o_cross     (w_cross)
  );

  // Count, terminal-count and done state; load beats step, done freezes stepping.
  always_ff @(posedge udb_counter_clk or posedge udb_counter_rst) begin
    if (udb_counter_rst) begin
      r_out  <= {WIDTH{1'b0}};
      r_tc   <= 1'b0;
      r_done <= 1'b0;
`ifdef UDB_COUNTER_BOUNCE_EN
      r_dir  <= UDB_DIR_UP;
`endif
    end else if (udb_counter_load) begin
      r_out  <= w_load_val;
      r_tc   <= 1'b0;
      r_done <= 1'b0;
`ifdef UDB_COUNTER_BOUNCE_EN
      r_dir  <= udb_counter_direction;
`endif
    end else if (udb_counter_en && !r_done && w_step_nz) begin
      r_out <= w_next;
      r_tc  <= w_cross;
      if (udb_counter_mode == UDB_MODE_ONESHOT && w_term) begin
        r_done <= 1'b1;
      end
`ifdef UDB_COUNTER_BOUNCE_EN
      if (udb_counter_mode == UDB_MODE_BOUNCE && w_cross) begin
        r_dir <= ~r_dir;
      end
`endif
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign udb_counter_out  = r_out;
  assign udb_counter_tc   = r_tc;
  assign udb_counter_done = r_done;

endmodule
